// File: rtl/result_dump_reader_pkg.sv
// -----------------------------------------------------------------------------
// result_dump_reader_pkg
//   Shared definitions for the multicycle control sequencer and the blocks
//   that watch it. Holds the sequencer phase codes so no consumer hard-codes
//   the numeric value of a phase.
// -----------------------------------------------------------------------------
package result_dump_reader_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef logic [SEQ_STATE_W-1:0] seq_state_t;

  // Sequencer phase codes.
  localparam seq_state_t STATE_IF     = 3'd0;
  localparam seq_state_t STATE_ID     = 3'd1;
  localparam seq_state_t STATE_EX     = 3'd2;
  localparam seq_state_t STATE_MEM    = 3'd3;
  localparam seq_state_t STATE_WB     = 3'd4;
  localparam seq_state_t STATE_OUTPUT = 3'd5;

endpackage

// File: rtl/result_dump_reader.sv
// -----------------------------------------------------------------------------
// result_dump_reader
//   Once the sequencer parks in STATE_OUTPUT, walks the register file through
//   its synchronous read port and streams each (address, data) pair over a
//   valid/ready interface. Raises a sticky done with a running XOR checksum of
//   all accepted beats once the last register has been taken.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   state      sequencer phase code (sampled only while idle)
//   rd_en      register-file read strobe (one cycle per register)
//   rd_addr    register-file read address
//   rd_data    register-file read data, valid the cycle after rd_en
//   out_valid  dump beat valid
//   out_ready  consumer accepts beat
//   out_addr   register index of the current beat
//   out_data   register value of the current beat
//   busy       dump in progress
//   done       dump complete, sticky until reset
//   checksum   XOR of all accepted out_data values
// -----------------------------------------------------------------------------
module result_dump_reader
  import result_dump_reader_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SEQ_STATE_W-1:0] state,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [DATA_W-1:0]      rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [DATA_W-1:0]      out_data,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_W-1:0]      checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } dump_state_t;

  // Full-width compare value so the walk can never wrap past the last entry.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_t         r_state;
  dump_state_t         w_next_state;
  logic [ADDR_W-1:0]   r_index;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [DATA_W-1:0]   r_out_data;
  logic [DATA_W-1:0]   r_checksum;
  logic                w_xfer;

  assign w_xfer = (r_state == S_SEND) && out_ready;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    rd_en        = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (state == STATE_OUTPUT) w_next_state = S_READ;
      end
      S_READ: begin
        rd_en        = 1'b1;
        busy         = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        busy         = 1'b1;
        w_next_state = S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          w_next_state = (r_index == LAST_IDX) ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Index, output holding register and checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_index    <= '0;
      r_out_addr <= '0;
      r_out_data <= '0;
      r_checksum <= '0;
    end else begin
      if (r_state == S_WAIT) begin
        r_out_data <= rd_data;
        r_out_addr <= r_index;
      end
      if (w_xfer) begin
        r_checksum <= r_checksum ^ r_out_data;
        // Hold at the last index; the FSM leaves for DONE instead of wrapping.
        if (r_index != LAST_IDX) r_index <= r_index + 1'b1;
      end
    end
  end

  assign rd_addr  = r_index;
  assign out_addr = r_out_addr;
  assign out_data = r_out_data;
  assign checksum = r_checksum;

endmodule

// File: tb/tb_result_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_result_dump_reader
//   Scoreboard bench: a behavioural register file answers reads, the expected
//   beat sequence is queued whenever a dump is launched, and a monitor pops
//   and compares on every accepted beat.
// -----------------------------------------------------------------------------
module tb_result_dump_reader;
  import result_dump_reader_pkg::*;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [SEQ_STATE_W-1:0] state;
  logic                   rd_en;
  logic [ADDR_W-1:0]      rd_addr;
  logic [DATA_W-1:0]      rd_data = '0;
  logic                   out_valid;
  logic                   out_ready;
  logic [ADDR_W-1:0]      out_addr;
  logic [DATA_W-1:0]      out_data;
  logic                   busy;
  logic                   done;
  logic [DATA_W-1:0]      checksum;

  logic [DATA_W-1:0] mem [NUM_REGS];
  beat_t             exp_q [$];
  int                total = 0;
  int                bad   = 0;

  result_dump_reader #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst), .state(state),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Behavioural register file with a one-cycle synchronous read.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // A dump delivers every register once, in ascending address order.
  task automatic push_dump();
    for (int i = 0; i < NUM_REGS; i++) begin
      beat_t b;
      b.addr = ADDR_W'(i);
      b.data = mem[i];
      exp_q.push_back(b);
    end
  endtask

  function automatic logic [DATA_W-1:0] xor_all();
    logic [DATA_W-1:0] x = '0;
    for (int i = 0; i < NUM_REGS; i++) x ^= mem[i];
    return x;
  endfunction

  // Monitor: a beat is accepted at the next rising edge when valid and ready
  // are both high mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 64'(out_addr), 64'hFFFF);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_addr", 64'(out_addr), 64'(e.addr));
          check("beat_data", 64'(out_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    int first_v;
    int done_n;
    logic ok;
    logic [DATA_W-1:0] held;
    logic [DATA_W-1:0] cks;
    logic stalled;

    // ---------------- reset state ----------------
    rst = 1'b1; state = STATE_IF; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 64'({rd_en, out_valid, busy, done}), 64'd0);
    check("rst_addrs", 64'({rd_addr, out_addr}), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_checksum", 64'(checksum), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ---------------- idle rejection ----------------
    ok = 1'b1;
    for (int c = 0; c < 50; c++) begin
      state     = SEQ_STATE_W'($urandom_range(0, 4));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (rd_en || out_valid || busy || done) ok = 1'b0;
    end
    check("idle_reject", 64'(ok), 64'd1);

    // ---------------- basic dump ----------------
    for (int i = 0; i < NUM_REGS; i++) mem[i] = 32'(i) * 32'h1111_1111;
    push_dump();
    out_ready = 1'b1;
    state     = STATE_OUTPUT;
    @(posedge clk);               // sampling edge
    first_v = 0; done_n = 0;
    // Cycle c is the c-th cycle following the sampling edge.
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (out_valid && first_v == 0) first_v = c;
      if (done) begin done_n = c; break; end
    end
    check("first_valid_cycle", 64'(first_v), 64'd3);
    // 96 full cycles elapse before done; it is first seen in cycle 97.
    check("done_cycle", 64'(done_n), 64'd97);
    check("basic_checksum", 64'(checksum), 64'(xor_all()));
    check("basic_q_empty", 64'(exp_q.size()), 64'd0);

    // ---------------- post-done stability ----------------
    cks = checksum;
    ok  = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 20; c++) begin
      state     = (c % 2 == 0) ? STATE_IF : STATE_OUTPUT;
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (rd_en || out_valid || busy || !done || checksum !== cks) ok = 1'b0;
    end
    check("post_done_stable", 64'(ok), 64'd1);

    // ---------------- backpressure + leave STATE_OUTPUT ----------------
    rst = 1'b1; #2; rst = 1'b0;
    check("rst2_done_clear", 64'({done, checksum}), 64'd0);
    for (int i = 0; i < NUM_REGS; i++) mem[i] = $urandom;
    push_dump();
    @(posedge clk); #1;
    state = STATE_OUTPUT; out_ready = 1'b1; stalled = 1'b0;
    begin : dump2
      for (int c = 0; c < 2000; c++) begin
        if (out_valid && out_addr == 5 && !stalled) begin
          stalled   = 1'b1;
          out_ready = 1'b0;
          held      = out_data;
          ok        = 1'b1;
          repeat (10) begin
            @(posedge clk); #1;
            if (!out_valid || out_addr != 5 || out_data !== held || rd_en) ok = 1'b0;
          end
          check("stall_hold", 64'(ok), 64'd1);
          out_ready = 1'b1;
        end else begin
          if (out_valid && out_addr == 10) state = STATE_IF;
          if (done) disable dump2;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
      end
    end
    check("dump2_done", 64'(done), 64'd1);
    check("dump2_state_left", 64'(state), 64'(STATE_IF));
    check("dump2_checksum", 64'(checksum), 64'(xor_all()));
    check("dump2_q_empty", 64'(exp_q.size()), 64'd0);

    // ---------------- async reset mid-dump ----------------
    rst = 1'b1; #2; rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NUM_REGS; i++) mem[i] = $urandom;
    push_dump();
    @(posedge clk); #1;
    state = STATE_OUTPUT; out_ready = 1'b1; ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (out_valid && out_addr == 7) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("reach_beat7", 64'(ok), 64'd1);
    out_ready = 1'b0;
    #2 rst = 1'b1;                // between edges, before the next negedge
    #1;
    check("async_rst_outs", 64'({out_valid, busy}), 64'd0);
    check("async_rst_checksum", 64'(checksum), 64'd0);
    // The aborted dump's remaining beats are never delivered.
    exp_q.delete();
    push_dump();
    out_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    done_n = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (done) begin done_n = c; break; end
    end
    check("restart_done_seen", 64'(done_n != 0), 64'd1);
    check("restart_checksum", 64'(checksum), 64'(xor_all()));
    check("restart_q_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
